axi4_rdata_checker: RTL and testbench
=====================================

Name: axi4_rdata_checker

Overview:
Memory-test read-data checker. Sits directly downstream of the AXI4 read sequencer and consumes its registered o_rdata/o_rvalid beat stream.
- Regenerates the expected write pattern per lane and compares it against every received beat.
- Reports per-beat mismatches, a saturating error count, beat progress, and a pass/fail verdict once all pTotalBeats beats have been checked.

Parameters:
- pAxi4BusWidth, 512, beat width in bits; must be a multiple of pDataBitWidth.
- pDataBitWidth, 16, lane width; LANES = pAxi4BusWidth/pDataBitWidth.
- pTotalBeats, 4096, beats per test pass; must be ≥1.
- pErrCntWidth, 16, error counter width.
- pSeed, 0, pattern value of lane 0 in beat 0.

Ports:
- iCLK  in  1  clock, single domain.
- iRST  in  1  synchronous, active-high reset.
- i_wdone  in  1  level from the write side; a rising edge arms a test pass.
- i_rdata  in  pAxi4BusWidth  read beat from the read sequencer.
- i_rvalid  in  1  qualifies i_rdata for one cycle; there is no backpressure.
- o_busy  out  1  high in RUN and DRAIN.
- o_done  out  1  high in DONE until the next arm or reset.
- o_pass  out  1  valid while o_done; 1 iff error count == 0.
- o_err_pulse  out  1  one-cycle pulse per mismatching beat.
- o_lane_err  out  LANES  mismatch mask of the latest checked beat; held until the next checked beat.
- o_err_cnt  out  pErrCntWidth  count of mismatching beats; saturates.
- o_beat_cnt  out  32  beats accepted in the current pass.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; pattern base = pSeed.
- Expected value, lane x of beat n: (pSeed + n*LANES + x) mod 2^pDataBitWidth. Lane x occupies bits [(x+1)*pDataBitWidth-1 : x*pDataBitWidth].
- Pattern generation: one base register advanced by LANES per accepted beat; lane offsets are constants. No multipliers.
- FSM states:
  - IDLE: on the i_wdone rising edge (registered previous value) clear the counters and base, then go to RUN.
  - RUN: each i_rvalid beat is accepted and o_beat_cnt increments. On the beat where o_beat_cnt reaches pTotalBeats, go to DRAIN.
  - DRAIN: wait until the pipeline is empty (2 cycles), then go to DONE.
  - DONE: hold the verdict. An i_wdone rising edge re-arms (clear counters, back to RUN).
- Pipeline, 2 stages:
  - S1 registers the per-lane compare vector and a valid bit.
  - S2 OR-reduces the vector. It drives o_lane_err, pulses o_err_pulse, and increments o_err_cnt.
  - Latency: o_err_pulse appears exactly 2 cycles after the i_rvalid cycle. Back-to-back beats are sustained at 1 beat/clk.
- o_err_cnt saturates at 2^pErrCntWidth-1 and never wraps.
- Ignored inputs:
  - i_rvalid in IDLE or DONE: no count, no compare.
  - i_rvalid in DRAIN: ignored (overrun beats are not checked).
  - i_wdone edge in RUN or DRAIN: ignored.
- Counter wrap: the pattern base wraps modulo 2^pDataBitWidth with no flag.
- Reset mid-pass: the pipeline is flushed, no error pulse is emitted, and the FSM returns to IDLE.

Optional Feature:
- Macro AXI4_RDATA_CHECKER_FIRST_ERR_EN.
- When defined, these ports are added:
  - o_first_err_beat, 32 bits: o_beat_cnt index of the first failing beat.
  - o_first_err_data, pAxi4BusWidth bits: received data of the first failing beat.
  - o_first_err_vld, 1 bit.
- Capture happens once per pass, on the S2 cycle of the first mismatch. The captured values are cleared at re-arm and at reset.
- When undefined: the ports are absent and no capture registers are inferred.

Decomposition:
- Shared package/header holds:
  - the state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3;
  - the LANES derivation;
  - the pattern-step function shared with the write-side pattern generator.
- Sub-module axi4_pattern_gen: base register with advance enable, synchronous clear, and LANES-wide expected-beat output. The write sequencer reuses it.

Test Plan (pAxi4BusWidth=64, pDataBitWidth=16, pTotalBeats=8, pSeed=0):
- Clean pass: i_wdone rises, 8 correct beats sent back-to-back (beat0 = 64'h0003_0002_0001_0000, beat1 = 64'h0007_0006_0005_0004, …) -> o_err_cnt=0; o_done=1 and o_pass=1 two cycles after the last beat.
- Single fault: beat 3 lane 2 = 16'hDEAD -> o_err_pulse exactly 2 cycles later, o_lane_err=4'b0100, final o_err_cnt=1, o_pass=0. With the macro defined: o_first_err_beat=3 and o_first_err_data captured.
- Saturation (pErrCntWidth=2, all 8 beats corrupted) -> o_err_cnt sticks at 3.
- Stray input: i_rvalid pulses in IDLE, and a 9th beat in DONE -> o_beat_cnt stays 0 and 8 respectively; o_err_cnt unchanged.
- Reset mid-pass: iRST high after beat 4, with a mismatch in flight -> no o_err_pulse; all outputs 0; the next i_wdone edge starts a fresh pass at pattern base 0.
- Re-arm: i_wdone low→high while in DONE -> counters cleared, o_done=0, o_busy=1 the next cycle.

Source files
------------

// File: rtl/axi4_rdata_checker_pkg.sv
// Shared definitions for the read-data checker and the write-side pattern generator:
// FSM encodings, lane-count derivation and the pattern-step function.
package axi4_rdata_checker_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int unsigned calc_lanes(input int unsigned bus_w, input int unsigned data_w);
        return bus_w / data_w;
    endfunction

    // Next pattern base after one beat; callers truncate to their lane width.
    function automatic logic [31:0] pattern_step(input logic [31:0] base, input int unsigned lanes);
        return base + lanes;
    endfunction

endpackage

// File: rtl/axi4_rdata_checker_if.sv
// Read-beat stream from the read sequencer into the checker.
interface axi4_rdata_checker_if #(
    parameter int unsigned pAxi4BusWidth = 512
);
    logic [pAxi4BusWidth-1:0] i_rdata;
    logic                     i_rvalid;

    modport master (output i_rdata, output i_rvalid);
    modport slave  (input  i_rdata, input  i_rvalid);
endinterface

// File: rtl/axi4_pattern_gen.sv
// Memory-test pattern source: one base register stepped by LANES per beat,
// lane x of the beat is base + x. Shared with the write sequencer.
module axi4_pattern_gen
    import axi4_rdata_checker_pkg::*;
#(
    parameter int unsigned pDataBitWidth = 16,
    parameter int unsigned pLanes        = 32,
    parameter int unsigned pSeed         = 0
) (
    input  logic                              iCLK,
    input  logic                              iRST,
    input  logic                              i_clr,
    input  logic                              i_adv,
    output logic [pLanes*pDataBitWidth-1:0]   o_expected
);

    logic [pDataBitWidth-1:0] r_base;
    logic [31:0]              w_next;

    assign w_next = pattern_step(32'(r_base), pLanes);

    always_ff @(posedge iCLK) begin
        if (iRST || i_clr) begin
            r_base <= pDataBitWidth'(pSeed);
        end else if (i_adv) begin
            r_base <= w_next[pDataBitWidth-1:0];
        end
    end

    always_comb begin
        o_expected = '0;
        for (int unsigned x = 0; x < pLanes; x++) begin
            o_expected[x*pDataBitWidth +: pDataBitWidth] = r_base + pDataBitWidth'(x);
        end
    end

endmodule

// File: rtl/axi4_rdata_checker.sv
// Memory-test read-data checker: compares each accepted beat with the regenerated
// pattern over a 2-stage pipeline. Optional first-error capture: AXI4_RDATA_CHECKER_FIRST_ERR_EN.
module axi4_rdata_checker
    import axi4_rdata_checker_pkg::*;
#(
    parameter int unsigned pAxi4BusWidth = 512,
    parameter int unsigned pDataBitWidth = 16,
    parameter int unsigned pTotalBeats   = 4096,
    parameter int unsigned pErrCntWidth  = 16,
    parameter int unsigned pSeed         = 0
) (
    input  logic                                   iCLK,
    input  logic                                   iRST,
    input  logic                                   i_wdone,
    axi4_rdata_checker_if.slave                    i_rd,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_pass,
    output logic                                   o_err_pulse,
    output logic [pAxi4BusWidth/pDataBitWidth-1:0] o_lane_err,
    output logic [pErrCntWidth-1:0]                o_err_cnt,
    output logic [31:0]                            o_beat_cnt
`ifdef AXI4_RDATA_CHECKER_FIRST_ERR_EN
    ,
    output logic [31:0]                            o_first_err_beat,
    output logic [pAxi4BusWidth-1:0]               o_first_err_data,
    output logic                                   o_first_err_vld
`endif
);

    localparam int unsigned LANES = calc_lanes(pAxi4BusWidth, pDataBitWidth);

    logic [1:0]               r_state;
    logic                     r_wdone_q;
    logic [31:0]              r_beat_cnt;
    logic                     w_wdone_rise;
    logic                     w_arm;
    logic                     w_accept;
    logic [pAxi4BusWidth-1:0] w_expected;
    logic [LANES-1:0]         w_mis;

    logic                     r_s1_vld;
    logic [LANES-1:0]         r_s1_mis;
    logic                     r_err_pulse;
    logic [LANES-1:0]         r_lane_err;
    logic [pErrCntWidth-1:0]  r_err_cnt;

    assign w_wdone_rise = i_wdone & ~r_wdone_q;
    assign w_arm        = w_wdone_rise && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_accept     = i_rd.i_rvalid && (r_state == ST_RUN);

    axi4_pattern_gen #(
        .pDataBitWidth (pDataBitWidth),
        .pLanes        (LANES),
        .pSeed         (pSeed)
    ) u_pattern_gen (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .i_clr      (w_arm),
        .i_adv      (w_accept),
        .o_expected (w_expected)
    );

    always_comb begin
        w_mis = '0;
        for (int unsigned x = 0; x < LANES; x++) begin
            w_mis[x] = i_rd.i_rdata[x*pDataBitWidth +: pDataBitWidth]
                       != w_expected[x*pDataBitWidth +: pDataBitWidth];
        end
    end

    // DRAIN lasts one cycle: the last beat sits in S1 on entry and leaves S2 on the same edge that enters DONE.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= ST_IDLE;
            r_wdone_q  <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_wdone_q <= i_wdone;
            if (w_arm) begin
                r_state    <= ST_RUN;
                r_beat_cnt <= '0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_accept) begin
                            r_beat_cnt <= r_beat_cnt + 32'd1;
                            if (r_beat_cnt == 32'(pTotalBeats - 1)) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: r_state <= ST_DONE;
                    default:  r_state <= r_state;
                endcase
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_s1_vld    <= 1'b0;
            r_s1_mis    <= '0;
            r_err_pulse <= 1'b0;
            r_lane_err  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_s1_vld    <= w_accept;
            r_s1_mis    <= w_mis;
            r_err_pulse <= r_s1_vld && (|r_s1_mis);
            if (r_s1_vld) begin
                r_lane_err <= r_s1_mis;
            end
            if (w_arm) begin
                r_err_cnt <= '0;
            end else if (r_s1_vld && (|r_s1_mis) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + pErrCntWidth'(1);
            end
        end
    end

`ifdef AXI4_RDATA_CHECKER_FIRST_ERR_EN
    logic [31:0]              r_s1_beat;
    logic [pAxi4BusWidth-1:0] r_s1_data;
    logic [31:0]              r_first_beat;
    logic [pAxi4BusWidth-1:0] r_first_data;
    logic                     r_first_vld;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_s1_beat    <= '0;
            r_s1_data    <= '0;
            r_first_beat <= '0;
            r_first_data <= '0;
            r_first_vld  <= 1'b0;
        end else begin
            r_s1_beat <= r_beat_cnt;
            r_s1_data <= i_rd.i_rdata;
            if (w_arm) begin
                r_first_beat <= '0;
                r_first_data <= '0;
                r_first_vld  <= 1'b0;
            end else if (r_s1_vld && (|r_s1_mis) && !r_first_vld) begin
                r_first_beat <= r_s1_beat;
                r_first_data <= r_s1_data;
                r_first_vld  <= 1'b1;
            end
        end
    end

    assign o_first_err_beat = r_first_beat;
    assign o_first_err_data = r_first_data;
    assign o_first_err_vld  = r_first_vld;
`endif

    assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done      = (r_state == ST_DONE);
    assign o_pass      = o_done && (r_err_cnt == '0);
    assign o_err_pulse = r_err_pulse;
    assign o_lane_err  = r_lane_err;
    assign o_err_cnt   = r_err_cnt;
    assign o_beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_axi4_rdata_checker.sv
// Bench for axi4_rdata_checker: randomized beats against an arithmetic pattern model,
// with a second instance using a 2-bit error counter to exercise saturation.
module tb_axi4_rdata_checker;

    localparam int unsigned BW   = 64;
    localparam int unsigned DW   = 16;
    localparam int unsigned NB   = 8;
    localparam int unsigned LN   = 4;
    localparam int unsigned SEED = 0;

    logic iCLK = 1'b0;
    logic iRST;
    logic i_wdone;

    axi4_rdata_checker_if #(.pAxi4BusWidth(BW)) bus ();

    logic        busy, done, pass, err_pulse;
    logic [3:0]  lane_err;
    logic [15:0] err_cnt;
    logic [31:0] beat_cnt;
    logic        s_busy, s_done, s_pass, s_err_pulse;
    logic [3:0]  s_lane_err;
    logic [1:0]  s_err_cnt;
    logic [31:0] s_beat_cnt;
`ifdef AXI4_RDATA_CHECKER_FIRST_ERR_EN
    logic [31:0] f_beat, sf_beat;
    logic [63:0] f_data, sf_data;
    logic        f_vld, sf_vld;
`endif

    axi4_rdata_checker #(
        .pAxi4BusWidth(BW), .pDataBitWidth(DW), .pTotalBeats(NB), .pErrCntWidth(16), .pSeed(SEED)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .i_wdone(i_wdone), .i_rd(bus.slave),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_pulse(err_pulse),
        .o_lane_err(lane_err), .o_err_cnt(err_cnt), .o_beat_cnt(beat_cnt)
`ifdef AXI4_RDATA_CHECKER_FIRST_ERR_EN
        , .o_first_err_beat(f_beat), .o_first_err_data(f_data), .o_first_err_vld(f_vld)
`endif
    );

    axi4_rdata_checker #(
        .pAxi4BusWidth(BW), .pDataBitWidth(DW), .pTotalBeats(NB), .pErrCntWidth(2), .pSeed(SEED)
    ) dut_sat (
        .iCLK(iCLK), .iRST(iRST), .i_wdone(i_wdone), .i_rd(bus.slave),
        .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_err_pulse(s_err_pulse),
        .o_lane_err(s_lane_err), .o_err_cnt(s_err_cnt), .o_beat_cnt(s_beat_cnt)
`ifdef AXI4_RDATA_CHECKER_FIRST_ERR_EN
        , .o_first_err_beat(sf_beat), .o_first_err_data(sf_data), .o_first_err_vld(sf_vld)
`endif
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    // Reference state: what the outputs should hold according to the pattern rules.
    logic [3:0]  m_lane = '0;
    int unsigned m_err  = 0;
    bit          m_first_vld = 1'b0;
    int unsigned m_first_beat = 0;
    logic [63:0] m_first_data = '0;

    function automatic logic [63:0] exp_beat(input int unsigned n);
        logic [63:0] v;
        v = '0;
        for (int unsigned x = 0; x < LN; x++) v[x*DW +: DW] = 16'((SEED + n*LN + x) % 65536);
        return v;
    endfunction

    function automatic logic [3:0] lane_mask(input int unsigned n, input logic [63:0] d);
        logic [63:0] e;
        logic [3:0]  m;
        e = exp_beat(n);
        m = '0;
        for (int unsigned x = 0; x < LN; x++) m[x] = (d[x*DW +: DW] != e[x*DW +: DW]);
        return m;
    endfunction

    function automatic logic [1:0] sat2(input int unsigned v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    // mode: 0 clean, 1 beat3/lane2=DEAD, 2 every beat corrupted, 3 random corruption
    task automatic run_pass(input string name, input int mode, input bit gaps, input bit do_arm);
        bit          ev_vld  [0:83];
        logic [3:0]  ev_mask [0:83];
        int unsigned ev_beat [0:83];
        logic [63:0] ev_data [0:83];
        int          b, last, lane;
        bit          fin;
        logic [63:0] d;
        logic [3:0]  mk;
        for (int i = 0; i < 84; i++) begin ev_vld[i] = 0; ev_mask[i] = '0; ev_beat[i] = 0; ev_data[i] = '0; end
        if (do_arm) begin
            @(negedge iCLK) i_wdone = 1'b0;
            @(negedge iCLK) i_wdone = 1'b1;
        end
        m_err = 0; m_first_vld = 0; m_first_beat = 0; m_first_data = '0;
        b = 0; last = -10; fin = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge iCLK);
            if (ev_vld[c]) begin
                m_lane = ev_mask[c];
                if (ev_mask[c] != 0) begin
                    m_err++;
                    if (!m_first_vld) begin
                        m_first_vld = 1; m_first_beat = ev_beat[c]; m_first_data = ev_data[c];
                    end
                end
            end
            total++;
            if (err_pulse !== (ev_vld[c] && ev_mask[c] != 0))
                $display("FAIL %s err_pulse c=%0d: got %b want %b", name, c, err_pulse, ev_vld[c] && ev_mask[c] != 0);
            total++;
            if (lane_err !== m_lane) begin bad++; $display("FAIL %s lane_err c=%0d: got %b want %b", name, c, lane_err, m_lane); end
            total++;
            if (beat_cnt !== 32'(b)) begin bad++; $display("FAIL %s beat_cnt c=%0d: got %0d want %0d", name, c, beat_cnt, b); end
            total++;
            if (s_err_cnt !== sat2(m_err)) begin bad++; $display("FAIL %s sat_err_cnt c=%0d: got %0d want %0d", name, c, s_err_cnt, sat2(m_err)); end
            if (err_pulse !== (ev_vld[c] && ev_mask[c] != 0)) bad++;
            if (c == last + 1) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL %s drain busy/done: got %b%b want 10", name, busy, done); end
            end
            if (c == last + 2) begin
                total++;
                if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s done/busy: got %b%b want 10", name, done, busy); end
                total++;
                if (pass !== (m_err == 0)) begin bad++; $display("FAIL %s pass: got %b want %b", name, pass, m_err == 0); end
                total++;
                if (err_cnt !== 16'(m_err)) begin bad++; $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, m_err); end
`ifdef AXI4_RDATA_CHECKER_FIRST_ERR_EN
                total++;
                if (f_vld !== m_first_vld) begin bad++; $display("FAIL %s first_vld: got %b want %b", name, f_vld, m_first_vld); end
                if (m_first_vld) begin
                    total++;
                    if (f_beat !== 32'(m_first_beat) || f_data !== m_first_data) begin
                        bad++; $display("FAIL %s first_err: got %0d/%h want %0d/%h", name, f_beat, f_data, m_first_beat, m_first_data);
                    end
                end
`endif
                fin = 1;
                break;
            end
            if (b < int'(NB) && (!gaps || $urandom_range(0, 2) != 0)) begin
                d = exp_beat(b);
                case (mode)
                    1: if (b == 3) d[2*DW +: DW] = 16'hDEAD;
                    2: begin lane = $urandom_range(0, 3); d[lane*DW +: DW] ^= 16'($urandom_range(1, 65535)); end
                    3: if ($urandom_range(0, 3) == 0) d ^= {$urandom, $urandom};
                    default: ;
                endcase
                mk = lane_mask(b, d);
                ev_vld[c+2] = 1; ev_mask[c+2] = mk; ev_beat[c+2] = b; ev_data[c+2] = d;
                bus.i_rdata = d; bus.i_rvalid = 1'b1;
                b++;
                if (b == int'(NB)) last = c;
            end else begin
                bus.i_rdata = {$urandom, $urandom}; bus.i_rvalid = 1'b0;
            end
        end
        bus.i_rvalid = 1'b0;
        total++;
        if (!fin) begin bad++; $display("FAIL %s timeout: got beats=%0d want %0d", name, b, NB); end
    endtask

    task automatic test_reset();
        iRST = 1'b1; i_wdone = 1'b0; bus.i_rvalid = 1'b0; bus.i_rdata = '0;
        repeat (3) @(negedge iCLK);
        total++;
        if ({busy, done, pass, err_pulse} !== 4'b0) begin bad++; $display("FAIL reset flags: got %b want 0000", {busy, done, pass, err_pulse}); end
        total++;
        if (lane_err !== '0 || err_cnt !== '0 || beat_cnt !== '0 || s_err_cnt !== '0) begin
            bad++; $display("FAIL reset counters: got %h/%0d/%0d/%0d want 0", lane_err, err_cnt, beat_cnt, s_err_cnt);
        end
        iRST = 1'b0; m_lane = '0; m_err = 0;
    endtask

    task automatic test_stray_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK); bus.i_rvalid = 1'b1; bus.i_rdata = {$urandom, $urandom} | 64'h1;
        end
        @(negedge iCLK) bus.i_rvalid = 1'b0;
        repeat (3) begin
            @(negedge iCLK);
            total++;
            if (err_pulse !== 1'b0) begin bad++; $display("FAIL idle err_pulse: got %b want 0", err_pulse); end
        end
        total++;
        if (beat_cnt !== 32'd0 || err_cnt !== 16'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle stray: got beat=%0d err=%0d busy=%b want 0/0/0", beat_cnt, err_cnt, busy);
        end
    endtask

    task automatic test_clean();
        run_pass("clean", 0, 0, 1);
    endtask

    task automatic test_single_fault();
        run_pass("single_fault", 1, 0, 1);
    endtask

    task automatic test_saturation();
        run_pass("saturation", 2, 0, 1);
        total++;
        if (s_err_cnt !== 2'd3 || err_cnt !== 16'd8) begin
            bad++; $display("FAIL saturation final: got sat=%0d wide=%0d want 3/8", s_err_cnt, err_cnt);
        end
    endtask

    task automatic test_stray_done();
        int unsigned prev;
        prev = m_err;
        @(negedge iCLK);
        bus.i_rvalid = 1'b1; bus.i_rdata = ~exp_beat(NB);
        @(negedge iCLK) bus.i_rvalid = 1'b0;
        repeat (3) begin
            @(negedge iCLK);
            total++;
            if (err_pulse !== 1'b0) begin bad++; $display("FAIL done_stray err_pulse: got %b want 0", err_pulse); end
        end
        total++;
        if (beat_cnt !== 32'(NB) || err_cnt !== 16'(prev) || done !== 1'b1) begin
            bad++; $display("FAIL done_stray: got beat=%0d err=%0d done=%b want %0d/%0d/1", beat_cnt, err_cnt, done, NB, prev);
        end
    endtask

    task automatic test_rearm();
        @(negedge iCLK) i_wdone = 1'b0;
        @(negedge iCLK) i_wdone = 1'b1;
        @(negedge iCLK);
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rearm done/busy: got %b%b want 01", done, busy); end
        total++;
        if (beat_cnt !== 32'd0 || err_cnt !== 16'd0 || s_err_cnt !== 2'd0) begin
            bad++; $display("FAIL rearm counters: got %0d/%0d/%0d want 0", beat_cnt, err_cnt, s_err_cnt);
        end
        run_pass("rearm_random", 3, 1, 0);
    endtask

    task automatic test_reset_midpass();
        logic [63:0] d;
        @(negedge iCLK) i_wdone = 1'b0;
        @(negedge iCLK) i_wdone = 1'b1;
        for (int unsigned n = 0; n < 4; n++) begin
            @(negedge iCLK);
            d = exp_beat(n);
            if (n == 3) d[$urandom_range(0, 3)*DW +: DW] ^= 16'h5A5A;
            bus.i_rvalid = 1'b1; bus.i_rdata = d;
        end
        @(negedge iCLK);
        iRST = 1'b1; bus.i_rvalid = 1'b0; i_wdone = 1'b0;
        @(negedge iCLK);
        total++;
        if (err_pulse !== 1'b0) begin bad++; $display("FAIL midreset err_pulse: got %b want 0", err_pulse); end
        total++;
        if ({busy, done, pass} !== 3'b0 || lane_err !== '0 || err_cnt !== '0 || beat_cnt !== '0) begin
            bad++; $display("FAIL midreset outputs: got %b %h %0d %0d want 0", {busy, done, pass}, lane_err, err_cnt, beat_cnt);
        end
        @(negedge iCLK);
        total++;
        if (err_pulse !== 1'b0) begin bad++; $display("FAIL midreset late pulse: got %b want 0", err_pulse); end
        iRST = 1'b0; m_lane = '0; m_err = 0;
        run_pass("after_reset", 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_stray_idle();
        test_clean();
        test_single_fault();
        test_saturation();
        test_stray_done();
        test_rearm();
        test_reset_midpass();
        for (int i = 0; i < 3; i++) run_pass("random", 3, 1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
